// File: rtl/regfile_multiport.sv
// regfile_multiport: integer register file with registered read ports, write-first bypass and a debug port
module regfile_multiport #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter int NUM_RD = 2,
    parameter int PRE_A_IDX = 1,
    parameter logic [XLEN-1:0] PRE_A_VAL = 1,
    parameter int PRE_B_IDX = 29,
    parameter logic [XLEN-1:0] PRE_B_VAL = 252,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic                   dbg_req,
    input  logic                   dbg_we,
    input  logic [AW-1:0]          dbg_addr,
    input  logic [XLEN-1:0]        dbg_wdata,
    output logic                   dbg_ack,
    output logic [XLEN-1:0]        dbg_rdata,
    output logic [NREGS*XLEN-1:0]  snapshot
);
    localparam logic [1:0] IDLE = 2'd0, PEND = 2'd1, ACK = 2'd2;

    logic [1:0]      state;
    logic [XLEN-1:0] regs [NREGS];
    logic            op_we;
    logic [AW-1:0]   op_addr;
    logic [XLEN-1:0] op_wdata;
    logic            dbg_go;

    // a pending debug op only proceeds in a cycle the pipeline is not writing
    assign dbg_go  = state == PEND && !wr_en;
    assign dbg_ack = state == ACK;

    function automatic logic [XLEN-1:0] reset_val(int i);
        return (i != 0 && i == PRE_A_IDX) ? PRE_A_VAL :
               (i != 0 && i == PRE_B_IDX) ? PRE_B_VAL : '0;
    endfunction

    // register array: presets on reset, pipeline writes, then committed debug writes; reg 0 never written
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (reset)
                regs[i] <= reset_val(i);
            else if (i != 0 && wr_en && wr_addr == AW'(i))
                regs[i] <= wr_data;
            else if (i != 0 && dbg_go && op_we && op_addr == AW'(i))
                regs[i] <= op_wdata;
        end
    end

    // registered read ports with write-first bypass of the pipeline write (debug writes are not bypassed)
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_RD; p++) begin
            if (reset)
                rd_data[p*XLEN +: XLEN] <= '0;
            else
                rd_data[p*XLEN +: XLEN] <= (wr_en && wr_addr != '0 && wr_addr == rd_addr[p*AW +: AW])
                                           ? wr_data : regs[rd_addr[p*AW +: AW]];
        end
    end

    // debug request/ack sequencer: accept and latch, wait out pipeline writes, perform, acknowledge
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_we     <= 1'b0;
            op_addr   <= '0;
            op_wdata  <= '0;
            dbg_rdata <= '0;
        end else if (state == IDLE && dbg_req) begin
            state    <= PEND;
            op_we    <= dbg_we;
            op_addr  <= dbg_addr;
            op_wdata <= dbg_wdata;
        end else if (dbg_go) begin
            state <= ACK;
            if (!op_we)
                dbg_rdata <= regs[op_addr];
        end else if (state == ACK) begin
            state <= IDLE;
        end
    end

    // flattened view of every register for the datapath display
    always_comb begin
        snapshot = '0;
        for (int i = 0; i < NREGS; i++)
            snapshot[i*XLEN +: XLEN] = regs[i];
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: randomized check of two register file configurations against an array model
module tb_regfile_multiport;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [9:0]    rd_addr = '0;
    logic [63:0]   rd_data;
    logic          wr_en = 1'b0;
    logic [4:0]    wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic          dbg_req = 1'b0;
    logic          dbg_we = 1'b0;
    logic [4:0]    dbg_addr = '0;
    logic [31:0]   dbg_wdata = '0;
    logic          dbg_ack;
    logic [31:0]   dbg_rdata;
    logic [1023:0] snapshot;

    logic [15:0]   rd_addr1 = '0;
    logic [63:0]   rd_data1;
    logic          wr_en1 = 1'b0;
    logic [3:0]    wr_addr1 = '0;
    logic [15:0]   wr_data1 = '0;
    logic          dbg_ack1;
    logic [15:0]   dbg_rdata1;
    logic [255:0]  snapshot1;

    regfile_multiport u0 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .snapshot(snapshot)
    );

    regfile_multiport #(.XLEN(16), .NREGS(16), .NUM_RD(4), .PRE_B_IDX(13), .PRE_B_VAL(16'h00FC)) u1 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(4'd0), .dbg_wdata(16'd0),
        .dbg_ack(dbg_ack1), .dbg_rdata(dbg_rdata1), .snapshot(snapshot1)
    );

    int total = 0;
    int bad = 0;

    logic [31:0] m [32];
    logic [31:0] e_rd [2];
    logic        e_ack;
    logic [31:0] e_rdata;
    bit          pend;
    logic        op_we;
    logic [4:0]  op_addr;
    logic [31:0] op_wdata;
    logic [15:0] m1 [16];
    logic [15:0] e_rd1 [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m[i]) m[i] = '0;
        foreach (m1[i]) m1[i] = '0;
        m[1] = 32'd1;
        m[29] = 32'd252;
        m1[1] = 16'd1;
        m1[13] = 16'h00FC;
        foreach (e_rd[i]) e_rd[i] = '0;
        foreach (e_rd1[i]) e_rd1[i] = '0;
        e_ack = 1'b0;
        e_rdata = '0;
        pend = 1'b0;
    endtask

    task automatic model_step();
        logic [4:0] ra;
        logic [3:0] ra1;
        if (reset) begin
            model_reset();
            return;
        end
        for (int p = 0; p < 2; p++) begin
            ra = rd_addr[p*5 +: 5];
            e_rd[p] = (wr_en && wr_addr != 0 && wr_addr == ra) ? wr_data : m[ra];
        end
        for (int p = 0; p < 4; p++) begin
            ra1 = rd_addr1[p*4 +: 4];
            e_rd1[p] = (wr_en1 && wr_addr1 != 0 && wr_addr1 == ra1) ? wr_data1 : m1[ra1];
        end
        if (e_ack) begin
            e_ack = 1'b0;
        end else if (pend) begin
            if (!wr_en) begin
                if (op_we) begin
                    if (op_addr != 0) m[op_addr] = op_wdata;
                end else begin
                    e_rdata = m[op_addr];
                end
                pend = 1'b0;
                e_ack = 1'b1;
            end
        end else if (dbg_req) begin
            pend = 1'b1;
            op_we = dbg_we;
            op_addr = dbg_addr;
            op_wdata = dbg_wdata;
        end
        if (wr_en && wr_addr != 0) m[wr_addr] = wr_data;
        if (wr_en1 && wr_addr1 != 0) m1[wr_addr1] = wr_data1;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        for (int p = 0; p < 2; p++) chk("rd", rd_data[p*32 +: 32], e_rd[p]);
        chk("ack", {31'd0, dbg_ack}, {31'd0, e_ack});
        chk("dbg_rdata", dbg_rdata, e_rdata);
        for (int i = 0; i < 32; i++) chk("snap", snapshot[i*32 +: 32], m[i]);
        for (int p = 0; p < 4; p++) chk("rd1", {16'd0, rd_data1[p*16 +: 16]}, {16'd0, e_rd1[p]});
        for (int i = 0; i < 16; i++) chk("snap1", {16'd0, snapshot1[i*16 +: 16]}, {16'd0, m1[i]});
    endtask

    function automatic logic [4:0] rnd_addr();
        return $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        logic [3:0] a;
        model_reset();
        cyc();
        cyc();
        chk("reset_ack", {31'd0, dbg_ack}, 32'd0);
        chk("reset_rd0", rd_data[31:0], 32'd0);

        reset = 1'b0;
        rd_addr = {5'd1, 5'd29};
        rd_addr1 = {4'd0, 4'd13, 4'd2, 4'd1};
        cyc();
        chk("t1_p0", rd_data[31:0], 32'd252);
        chk("t1_p1", rd_data[63:32], 32'd1);
        chk("t6_p0", {16'd0, rd_data1[15:0]}, 32'd1);
        chk("t6_p1", {16'd0, rd_data1[31:16]}, 32'd0);
        chk("t6_p2", {16'd0, rd_data1[47:32]}, 32'h00FC);
        chk("t6_p3", {16'd0, rd_data1[63:48]}, 32'd0);

        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        rd_addr = {5'd1, 5'd5};
        cyc();
        chk("t2_bypass", rd_data[31:0], 32'hDEADBEEF);

        wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rd_addr = {5'd0, 5'd0};
        cyc();
        chk("t3_bypass0", rd_data[31:0], 32'd0);
        wr_en = 1'b0;
        cyc();
        chk("t3_rd0", rd_data[31:0], 32'd0);
        chk("t3_snap0", snapshot[31:0], 32'd0);

        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h1234;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
        cyc();
        chk("t4_stall1", {31'd0, dbg_ack}, 32'd0);
        dbg_addr = 5'd8; dbg_wdata = 32'h9999;
        cyc();
        chk("t4_stall2", {31'd0, dbg_ack}, 32'd0);
        cyc();
        chk("t4_stall3", {31'd0, dbg_ack}, 32'd0);
        wr_en = 1'b0;
        cyc();
        chk("t4_ack", {31'd0, dbg_ack}, 32'd1);
        dbg_req = 1'b0;
        rd_addr = {5'd8, 5'd7};
        cyc();
        chk("t4_rd7", rd_data[31:0], 32'h1234);
        chk("t4_rd8", rd_data[63:32], 32'd0);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7;
        for (int k = 0; k < 10 && !dbg_ack; k++) cyc();
        chk("t4_rd_ack", {31'd0, dbg_ack}, 32'd1);
        chk("t4_rdata", dbg_rdata, 32'h1234);
        dbg_req = 1'b0;
        cyc();

        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'hAAAA;
        wr_en = 1'b1; wr_addr = 5'd4;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0; wr_en = 1'b0; dbg_req = 1'b0;
        rd_addr = {5'd9, 5'd9};
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t5_noack", {31'd0, dbg_ack}, 32'd0);
        end
        chk("t5_rd9", rd_data[31:0], 32'd0);

        for (int n = 0; n < 2500; n++) begin
            reset = $urandom_range(0, 199) == 0;
            rd_addr = {rnd_addr(), rnd_addr()};
            wr_en = $urandom_range(0, 1) == 1;
            wr_addr = rnd_addr();
            wr_data = $urandom;
            if (dbg_req && dbg_ack) dbg_req = $urandom_range(0, 3) == 0;
            else if (!dbg_req) dbg_req = $urandom_range(0, 3) == 0;
            dbg_we = $urandom_range(0, 1) == 1;
            dbg_addr = rnd_addr();
            dbg_wdata = $urandom;
            a = 4'($urandom_range(0, 15));
            rd_addr1 = $urandom_range(0, 1) ? {a + 4'd3, a + 4'd2, a + 4'd1, a}
                                            : {a, a + 4'd5, a + 4'd9, a + 4'd14};
            wr_en1 = $urandom_range(0, 1) == 1;
            wr_addr1 = 4'($urandom_range(0, 15));
            wr_data1 = 16'($urandom);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
